// File: rtl/dac_pkg.sv
// Shared constants, types and helpers for the DAC sample-capture and DAC output stage.
package dac_pkg;

  localparam logic [15:0] DAC_MIDSCALE           = 16'h8000;
  localparam int          DEF_NUM_STREAMS        = 8;
  localparam int          DEF_CHANNELS_PER_FRAME = 35;
  localparam int          DEF_PIPE_DELAY         = 2;

  // SPI sequencer state in which the MISO words of the current slot are valid.
  localparam logic [31:0] MS_CAPTURE = 32'd160;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_HELD
  } cap_state_e;

  typedef struct packed {
    logic [4:0] stream;
    logic [5:0] channel;
    logic       en;
  } dac_cfg_t;

  // Slot in which the data for command slot ch returns, wrapped back into the frame.
  function automatic logic [5:0] capture_slot(input logic [5:0] ch, input int delay,
                                              input int slots);
    logic [6:0] sum;
    sum = {1'b0, ch} + 7'(delay);
    if (sum >= 7'(slots)) sum = sum - 7'(slots);
    return sum[5:0];
  endfunction

endpackage

// File: rtl/dac_stream_mux.sv
// Combinational DAC source selector: one of NUM_STREAMS MISO words, the manual
// software value, or midscale for any out-of-range selection.
module dac_stream_mux
  import dac_pkg::*;
#(
  parameter int NUM_STREAMS = DEF_NUM_STREAMS
) (
  input  logic [16*NUM_STREAMS-1:0] i_data_stream_flat,
  input  logic [4:0]                i_stream_sel,
  input  logic [15:0]               i_manual,
  output logic [15:0]               o_word
);

  always_comb begin
    // NOTE: o_word gets a value before any branch, so no path can leave it unassigned and infer a latch.
    o_word = DAC_MIDSCALE;
    if (int'(i_stream_sel) == NUM_STREAMS) o_word = i_manual;
    for (int k = 0; k < NUM_STREAMS; k++) begin
      if (int'(i_stream_sel) == k) o_word = i_data_stream_flat[16*k +: 16];
    end
  end

endmodule

// File: rtl/dac_sample_capture.sv
// Picks one amplifier sample per SPI frame and presents it, frame-aligned and held,
// to the DAC output stage together with a frame-aligned enable.
module dac_sample_capture
  import dac_pkg::*;
#(
  parameter int          NUM_STREAMS        = DEF_NUM_STREAMS,
  parameter int          CHANNELS_PER_FRAME = DEF_CHANNELS_PER_FRAME,
  parameter int          PIPE_DELAY         = DEF_PIPE_DELAY,
  parameter logic [31:0] MS_CAPTURE_STATE   = MS_CAPTURE
) (
  input  logic                      dataclk,
  input  logic                      reset,
  input  logic [31:0]               main_state,
  input  logic [5:0]                channel,
  input  logic [16*NUM_STREAMS-1:0] data_stream_flat,
  input  logic [4:0]                stream_sel,
  input  logic [5:0]                channel_sel,
  input  logic [15:0]               DAC_manual,
  input  logic                      cfg_en,
  output logic [15:0]               DAC_input,
  output logic                      DAC_en,
  output logic                      sample_valid,
  output logic                      stale
);

  cap_state_e  r_state;
  cap_state_e  w_state_nxt;
  dac_cfg_t    r_act_cfg;
  logic [15:0] r_shadow;
  logic [15:0] r_dac_input;
  logic        r_dac_en;
  logic        r_sample_valid;
  logic        r_stale;

  logic [5:0]  w_cap_ch;
  logic        w_in_capture_state;
  logic        w_capture;
  logic        w_commit;
  logic [15:0] w_sel_word;

  // Data for the selected channel comes back PIPE_DELAY slots after its command.
  assign w_cap_ch           = capture_slot(r_act_cfg.channel, PIPE_DELAY, CHANNELS_PER_FRAME);
  assign w_in_capture_state = (main_state == MS_CAPTURE_STATE);
  assign w_capture          = w_in_capture_state && (channel == w_cap_ch);
  assign w_commit           = w_in_capture_state && (channel == 6'(CHANNELS_PER_FRAME - 1));

  dac_stream_mux #(
    .NUM_STREAMS(NUM_STREAMS)
  ) u_stream_mux (
    .i_data_stream_flat(data_stream_flat),
    .i_stream_sel      (r_act_cfg.stream),
    .i_manual          (DAC_manual),
    .o_word            (w_sel_word)
  );

  always_ff @(posedge dataclk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_commit) w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (w_commit)       w_state_nxt = S_WAIT;
        else if (w_capture) w_state_nxt = S_HELD;
      end
      S_HELD: if (w_commit) w_state_nxt = S_WAIT;
      default:              w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge dataclk) begin
    if (reset) begin
      r_act_cfg      <= '0;
      // NOTE: the shadow word is cleared too; it is never presented before a capture, but stays X-free.
      r_shadow       <= '0;
      r_dac_input    <= DAC_MIDSCALE;
      r_dac_en       <= 1'b0;
      r_sample_valid <= 1'b0;
      r_stale        <= 1'b0;
    end else begin
      r_sample_valid <= 1'b0;

      // A capture landing on the commit slot bypasses the shadow below.
      if (w_capture && !w_commit && (r_state != S_IDLE)) r_shadow <= w_sel_word;

      if (w_commit) begin
        r_act_cfg <= '{stream: stream_sel, channel: channel_sel, en: cfg_en};
        // The first commit after reset only loads configuration.
        if (r_state != S_IDLE) begin
          r_dac_en <= r_act_cfg.en;
          if (!r_act_cfg.en) begin
            r_dac_input <= DAC_MIDSCALE;
            r_stale     <= 1'b0;
          end else if (w_capture) begin
            r_dac_input    <= w_sel_word;
            r_sample_valid <= 1'b1;
            r_stale        <= 1'b0;
          end else if (r_state == S_HELD) begin
            r_dac_input    <= r_shadow;
            r_sample_valid <= 1'b1;
            r_stale        <= 1'b0;
          end else begin
            r_stale <= 1'b1;
          end
        end
      end
    end
  end

  assign DAC_input    = r_dac_input;
  assign DAC_en       = r_dac_en;
  assign sample_valid = r_sample_valid;
  assign stale        = r_stale;

endmodule

// File: tb/tb_dac_sample_capture.sv
// Frame-level bench for dac_sample_capture: a sequencer model drives 35-slot frames,
// expected DAC words are queued per frame and matched against each sample_valid pulse.
module tb_dac_sample_capture;

  localparam int          NS       = 8;
  localparam int          CPF      = 35;
  localparam logic [31:0] MS_CAP   = 32'd160;
  localparam logic [31:0] MS_OTHER = 32'd100;

  logic          dataclk;
  logic          reset;
  logic [31:0]   main_state;
  logic [5:0]    channel;
  logic [16*NS-1:0] data_stream_flat;
  logic [4:0]    stream_sel;
  logic [5:0]    channel_sel;
  logic [15:0]   DAC_manual;
  logic          cfg_en;
  logic [15:0]   DAC_input;
  logic          DAC_en;
  logic          sample_valid;
  logic          stale;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] sb[$];
  logic [15:0] mon_exp;

  logic [15:0] ovr_word   = '0;
  int          ovr_stream = 0;
  int          ovr_ch     = -1;
  int          skip_ch    = -1;
  logic        hold_en    = 1'b0;
  logic [15:0] hold_val   = '0;

  dac_sample_capture #(
    .NUM_STREAMS       (NS),
    .CHANNELS_PER_FRAME(CPF),
    .PIPE_DELAY        (2),
    .MS_CAPTURE_STATE  (MS_CAP)
  ) dut (
    .dataclk         (dataclk),
    .reset           (reset),
    .main_state      (main_state),
    .channel         (channel),
    .data_stream_flat(data_stream_flat),
    .stream_sel      (stream_sel),
    .channel_sel     (channel_sel),
    .DAC_manual      (DAC_manual),
    .cfg_en          (cfg_en),
    .DAC_input       (DAC_input),
    .DAC_en          (DAC_en),
    .sample_valid    (sample_valid),
    .stale           (stale)
  );

  initial dataclk = 1'b0;
  always #5 dataclk = ~dataclk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [15:0] bg_word(input int k, input int ch);
    logic [15:0] w;
    w = 16'(k * 4096 + 256 + ch);
    return w;
  endfunction

  // Two cycles per slot: a non-capture state, then MS_CAP (unless suppressed).
  task automatic run_slots(input int from_ch, input int to_ch);
    for (int ch = from_ch; ch <= to_ch; ch++) begin
      @(negedge dataclk);
      if (hold_en) begin
        check("hold_dac", 32'(DAC_input), 32'(hold_val));
        check("hold_valid", 32'(sample_valid), 32'd0);
      end
      channel    = 6'(ch);
      main_state = MS_OTHER;
      for (int k = 0; k < NS; k++)
        data_stream_flat[16*k +: 16] = (k == ovr_stream && ch == ovr_ch) ? ovr_word : bg_word(k, ch);
      @(negedge dataclk);
      main_state = (ch == skip_ch) ? MS_OTHER : MS_CAP;
    end
    @(negedge dataclk);
    main_state = MS_OTHER;
  endtask

  task automatic frame(input logic [15:0] word, input int strm, input int ch);
    ovr_word   = word;
    ovr_stream = strm;
    ovr_ch     = ch;
    run_slots(0, CPF - 1);
  endtask

  // Scoreboard: every sample_valid pulse must match the oldest queued word.
  initial begin
    forever begin
      @(posedge dataclk);
      #1;
      if (sample_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_valid", 32'(sample_valid), 32'd0);
        end else begin
          mon_exp = sb.pop_front();
          check("sb_word", 32'(DAC_input), 32'(mon_exp));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset            = 1'b1;
    main_state       = MS_OTHER;
    channel          = '0;
    data_stream_flat = '0;
    stream_sel       = 5'd2;
    channel_sel      = 6'd5;
    DAC_manual       = '0;
    cfg_en           = 1'b1;
    repeat (3) @(negedge dataclk);
    reset = 1'b0;
    check("rst_dac", 32'(DAC_input), 32'h8000);
    check("rst_en", 32'(DAC_en), 32'd0);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_stale", 32'(stale), 32'd0);

    // Basic capture: first commit only loads config, second presents stream 2 slot 7.
    frame(16'h1234, 2, 7);
    check("t1_idle_en", 32'(DAC_en), 32'd0);
    check("t1_idle_dac", 32'(DAC_input), 32'h8000);
    sb.push_back(16'h1234);
    frame(16'h1234, 2, 7);
    check("t1_dac", 32'(DAC_input), 32'h1234);
    check("t1_en", 32'(DAC_en), 32'd1);
    check("t1_valid", 32'(sample_valid), 32'd1);
    hold_en  = 1'b1;
    hold_val = 16'h1234;
    sb.push_back(16'h5678);
    frame(16'h5678, 2, 7);
    hold_en = 1'b0;
    check("t1_next", 32'(DAC_input), 32'h5678);

    // Wrapped capture slot: channel 33 + 2 lands in slot 0 of the next frame.
    channel_sel = 6'd33;
    sb.push_back(16'h1111);
    frame(16'h1111, 2, 7);
    sb.push_back(16'hABCD);
    frame(16'hABCD, 2, 0);
    check("t2_dac", 32'(DAC_input), 32'hABCD);
    check("t2_stale", 32'(stale), 32'd0);
    channel_sel = 6'd32;
    sb.push_back(16'h2222);
    frame(16'h2222, 2, 0);
    check("t2_steady_stale", 32'(stale), 32'd0);

    // Capture slot coincides with the commit slot.
    sb.push_back(16'h0F0F);
    frame(16'h0F0F, 2, 34);
    check("t3_dac", 32'(DAC_input), 32'h0F0F);
    check("t3_valid", 32'(sample_valid), 32'd1);

    // Disable, then change stream and enable mid-frame.
    channel_sel = 6'd5;
    cfg_en      = 1'b0;
    sb.push_back(16'h4444);
    frame(16'h4444, 2, 34);
    check("t4_en_lag", 32'(DAC_en), 32'd1);
    frame(16'h1357, 2, 7);
    check("t4_off_dac", 32'(DAC_input), 32'h8000);
    check("t4_off_en", 32'(DAC_en), 32'd0);
    ovr_word   = 16'h5555;
    ovr_stream = 3;
    ovr_ch     = 7;
    run_slots(0, 9);
    stream_sel = 5'd3;
    cfg_en     = 1'b1;
    check("t4_mid_en", 32'(DAC_en), 32'd0);
    run_slots(10, CPF - 1);
    check("t4_old_cfg_dac", 32'(DAC_input), 32'h8000);
    check("t4_old_cfg_en", 32'(DAC_en), 32'd0);
    sb.push_back(16'h3A3A);
    ovr_word = 16'h3A3A;
    run_slots(0, 20);
    check("t4_en_pre_commit", 32'(DAC_en), 32'd0);
    run_slots(21, CPF - 1);
    check("t4_dac", 32'(DAC_input), 32'h3A3A);
    check("t4_en", 32'(DAC_en), 32'd1);

    // Manual source, out-of-range select, disable.
    stream_sel = 5'd8;
    DAC_manual = 16'hC000;
    sb.push_back(16'h6666);
    frame(16'h6666, 3, 7);
    check("t5_last_stream", 32'(DAC_input), 32'h6666);
    stream_sel = 5'd9;
    sb.push_back(16'hC000);
    frame(16'h6767, 3, 7);
    check("t5_manual", 32'(DAC_input), 32'hC000);
    cfg_en = 1'b0;
    sb.push_back(16'h8000);
    frame(16'h6868, 3, 7);
    check("t5_midscale", 32'(DAC_input), 32'h8000);
    check("t5_mid_en", 32'(DAC_en), 32'd1);
    cfg_en     = 1'b1;
    stream_sel = 5'd2;
    frame(16'h6969, 2, 7);
    check("t5_dis_dac", 32'(DAC_input), 32'h8000);
    check("t5_dis_en", 32'(DAC_en), 32'd0);

    // Missed capture, then reset in the middle of a frame.
    sb.push_back(16'h7777);
    frame(16'h7777, 2, 7);
    check("t6_dac", 32'(DAC_input), 32'h7777);
    skip_ch = 7;
    frame(16'h1F1F, 2, 7);
    skip_ch = -1;
    check("t6_stale", 32'(stale), 32'd1);
    check("t6_stale_hold", 32'(DAC_input), 32'h7777);
    sb.push_back(16'h7878);
    frame(16'h7878, 2, 7);
    check("t6_recover_stale", 32'(stale), 32'd0);
    check("t6_recover_dac", 32'(DAC_input), 32'h7878);
    ovr_word   = 16'h9999;
    ovr_stream = 2;
    ovr_ch     = 7;
    run_slots(0, 10);
    reset = 1'b1;
    @(negedge dataclk);
    reset = 1'b0;
    check("t6_rst_dac", 32'(DAC_input), 32'h8000);
    check("t6_rst_en", 32'(DAC_en), 32'd0);
    check("t6_rst_valid", 32'(sample_valid), 32'd0);
    check("t6_rst_stale", 32'(stale), 32'd0);
    run_slots(11, CPF - 1);
    check("t6_dropped_dac", 32'(DAC_input), 32'h8000);
    check("t6_dropped_en", 32'(DAC_en), 32'd0);
    sb.push_back(16'hAAAA);
    frame(16'hAAAA, 2, 7);
    check("t6_after_rst_dac", 32'(DAC_input), 32'hAAAA);
    check("t6_after_rst_en", 32'(DAC_en), 32'd1);

    repeat (3) @(negedge dataclk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dac_sample_capture.md
Name: dac_sample_capture

Overview:
- Upstream feeder for the scalable HPF DAC output stage.
- Picks one amplifier sample per SPI frame from the demultiplexed MISO data streams, using the selected stream and channel, compensating for command-pipeline delay.
- Holds the sample on DAC_input for a whole frame, so the downstream HPF state update (channel 0) and serial shift-out (channels 19..34) see a stable word.
- Frame-aligns the configuration so that software writes never cause mid-frame glitches.

Parameters:
- NUM_STREAMS, 8, number of 16-bit MISO data streams on data_stream_flat.
- CHANNELS_PER_FRAME, 35, command slots per frame (channel counts 0..CHANNELS_PER_FRAME-1).
- PIPE_DELAY, 2, command-to-data latency in channel slots.
- ms_capture, 160, main_state value at which the MISO words for the current channel are valid.

Ports:
- dataclk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- main_state  in  32  global SPI sequencer state
- channel  in  6  current command slot
- data_stream_flat  in  16*NUM_STREAMS  stream k occupies bits [16k+15:16k], offset-binary
- stream_sel  in  5  0..NUM_STREAMS-1 selects a stream; ==NUM_STREAMS selects DAC_manual; >NUM_STREAMS forces midscale
- channel_sel  in  6  amplifier channel 0..31
- DAC_manual  in  16  software-supplied value
- cfg_en  in  1  requested DAC enable
- DAC_input  out  16  held sample to the DAC stage, offset-binary
- DAC_en  out  1  frame-aligned enable to the DAC stage
- sample_valid  out  1  one-cycle pulse when DAC_input updates with a fresh capture
- stale  out  1  high when the last commit found no capture

Behaviour:
- Reset (synchronous, active-high):
  - DAC_input=16'h8000; DAC_en=0; sample_valid=0; stale=0.
  - Shadow registers clear; active config = stream 0, channel 0, en 0; FSM goes to S_IDLE.
  - Reset mid-frame discards any pending capture.
- Capture slot:
  - cap_ch = act_channel + PIPE_DELAY.
  - If cap_ch >= CHANNELS_PER_FRAME, subtract CHANNELS_PER_FRAME (wrap). A wrapped capture lands early in the following frame; this is accepted.
  - Capture event = (main_state==ms_capture) && (channel==cap_ch). It fires at most once per frame.
- Source mux, applied at the capture event:
  - stream_sel < NUM_STREAMS: that stream's word.
  - stream_sel == NUM_STREAMS: DAC_manual.
  - Otherwise: 16'h8000.
  - The result is written to shadow_sample and sets the captured flag.
- Commit event = (main_state==ms_capture) && (channel==CHANNELS_PER_FRAME-1). Exactly one cycle per frame. Registered outputs update on the following edge.
  - act_en=0: DAC_input=16'h8000, sample_valid=0, stale=0.
  - act_en=1 and captured: DAC_input=shadow_sample, sample_valid=1 for one cycle, stale=0.
  - act_en=1 and not captured: DAC_input holds, stale=1, sample_valid=0.
  - DAC_en <= act_en.
  - Active config <= (stream_sel, channel_sel, cfg_en) sampled at this cycle. New config governs the next frame only.
  - captured flag clears.
- Simultaneous capture and commit (cap_ch==CHANNELS_PER_FRAME-1): the capture bypasses the shadow. DAC_input takes the selected word in the same commit, and sample_valid=1. Old active config governs this selection.
- FSM:
  - S_IDLE: outputs at reset values. First commit goes to S_WAIT; this commit only loads config.
  - S_WAIT: no capture yet this frame. Capture goes to S_HELD; commit stays in S_WAIT (stale path).
  - S_HELD: holds shadow. Commit goes to S_WAIT.
  - A capture while already in S_HELD is impossible by construction; if forced, the newest sample overwrites.
- Inputs with channel_sel >= 32 are accepted unchanged; the wrap arithmetic still applies.
- Outputs are registered. DAC_input changes only in the cycle after a commit, never during channels 0..33.

Decomposition:
- Shared package (dac_pkg):
  - DAC_MIDSCALE = 16'h8000.
  - FSM state enum (S_IDLE, S_WAIT, S_HELD).
  - CHANNELS_PER_FRAME default.
  - The ms_* state constants shared with the DAC output stage.
- One sub-module: dac_stream_mux, a combinational NUM_STREAMS+manual+midscale selector, reusable by the other DAC channels.
- The top instantiates it once. One dac_sample_capture is instantiated per DAC output.

Test Plan:
1. Reset, then 3 frames with cfg_en=1, stream_sel=2, channel_sel=5, stream 2 = 16'h1234 at channel 7 → after the 2nd commit, DAC_input=16'h1234 and a 1-cycle sample_valid. DAC_input is constant over channels 0..34 of the next frame.
2. channel_sel=33, PIPE_DELAY=2 → capture at channel 0 of the next frame (wrap). Stream value 16'hABCD appears after that frame's commit; no stale in steady state.
3. channel_sel=32 (cap_ch=34, same cycle as commit) with word 16'h0F0F → DAC_input=16'h0F0F on the commit edge, sample_valid=1.
4. Change stream_sel 2→3 and cfg_en 0→1 mid-frame → the current frame still uses the old config. The next frame commits stream 3 data. DAC_en rises only at the commit edge.
5. stream_sel=8 with DAC_manual=16'hC000 → DAC_input=16'hC000. stream_sel=9 → 16'h8000. cfg_en=0 → DAC_input=16'h8000 and DAC_en=0.
6. Suppress main_state==ms_capture at cap_ch for one frame → stale=1 and DAC_input is held. Assert reset mid-frame → all outputs return to reset values the next cycle, and the pending capture is dropped.
